// File: rtl/gen_multi_done.sv
// rtl/gen_multi_done.sv - per-tile done aggregator with enable mask, duplicate detection and watchdog
// Collects one-cycle done pulses from enabled engines and emits a single all_done pulse per tile.
module gen_multi_done #(
  parameter int NUM_CH = 3,
  parameter int TO_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] ch_done,
  input  logic [TO_W-1:0]   timeout_cycles,
  output logic              all_done,
  output logic              busy,
  output logic [NUM_CH-1:0] ch_pending,
  output logic              dup_err,
  output logic              timeout_err
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] kept_q, kept_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [TO_W-1:0]   limit_q, limit_d;
  logic              all_done_d;
  logic              dup_err_d;
  logic              timeout_err_d;
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] dup;
  logic [NUM_CH-1:0] nxt;
  logic              expire;

  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    kept_d        = kept_q;
    cnt_d         = cnt_q;
    limit_d       = limit_q;
    all_done_d    = 1'b0;
    dup_err_d     = 1'b0;
    timeout_err_d = 1'b0;

    hit    = ch_done & mask_q;
    dup    = hit & kept_q;
    nxt    = kept_q | hit;
    expire = (limit_q != '0) && (cnt_q == (limit_q - TO_W'(1)));

    case (state_q)
      IDLE: begin
        if (start) begin
          mask_d  = ch_en;
          kept_d  = '0;
          cnt_d   = '0;
          limit_d = timeout_cycles;
          // An empty mask completes immediately without ever opening a transaction.
          if (ch_en == '0) begin
            all_done_d = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        dup_err_d = |dup;
        // Completion is tested before expiry so a last done on the expiry cycle still wins.
        if (nxt == mask_q) begin
          all_done_d = 1'b1;
          state_d    = IDLE;
          kept_d     = '0;
        end else if (expire) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
          kept_d        = '0;
        end else begin
          kept_d = nxt;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + TO_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      kept_q      <= '0;
      cnt_q       <= '0;
      limit_q     <= '0;
      all_done    <= 1'b0;
      busy        <= 1'b0;
      ch_pending  <= '0;
      dup_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      kept_q      <= kept_d;
      cnt_q       <= cnt_d;
      limit_q     <= limit_d;
      all_done    <= all_done_d;
      busy        <= (state_d == WAIT);
      ch_pending  <= (state_d == WAIT) ? (mask_d & ~kept_d) : '0;
      dup_err     <= dup_err_d;
      timeout_err <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_gen_multi_done.sv
// tb/tb_gen_multi_done.sv - directed self-checking bench for gen_multi_done
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_gen_multi_done;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  ch_en;
  logic [2:0]  ch_done;
  logic [15:0] timeout_cycles;
  logic        all_done;
  logic        busy;
  logic [2:0]  ch_pending;
  logic        dup_err;
  logic        timeout_err;

  int pass_cnt;
  int total_cnt;

  gen_multi_done #(.NUM_CH(3), .TO_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .ch_en          (ch_en),
    .ch_done        (ch_done),
    .timeout_cycles (timeout_cycles),
    .all_done       (all_done),
    .busy           (busy),
    .ch_pending     (ch_pending),
    .dup_err        (dup_err),
    .timeout_err    (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
    start   = 1'b0;
    ch_done = 3'b000;
  endtask

  task automatic open_tile(input logic [2:0] en, input logic [15:0] to);
    ch_en          = en;
    timeout_cycles = to;
    start          = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    total_cnt++; if ({all_done, busy, dup_err, timeout_err} !== 4'b0000) $display("FAIL reset_flags got=%b exp=0000", {all_done, busy, dup_err, timeout_err}); else pass_cnt++;
    total_cnt++; if (ch_pending !== 3'b000) $display("FAIL reset_pending got=%b exp=000", ch_pending); else pass_cnt++;
    // done pulses in IDLE must be ignored
    ch_done = 3'b111;
    cyc();
    total_cnt++; if ({all_done, busy, dup_err} !== 3'b000) $display("FAIL idle_done_ignored got=%b exp=000", {all_done, busy, dup_err}); else pass_cnt++;
  endtask

  task automatic test_out_of_order();
    logic [2:0] exp_pend;
    open_tile(3'b111, 16'd0);
    total_cnt++; if (busy !== 1'b1 || ch_pending !== 3'b111) $display("FAIL ooo_open busy=%b pend=%b exp busy=1 pend=111", busy, ch_pending); else pass_cnt++;
    for (int k = 1; k <= 9; k++) begin
      ch_done = (k == 2) ? 3'b100 : (k == 5) ? 3'b001 : (k == 9) ? 3'b010 : 3'b000;
      cyc();
      exp_pend = (k < 2) ? 3'b111 : (k < 5) ? 3'b011 : (k < 9) ? 3'b010 : 3'b000;
      total_cnt++; if (all_done !== (k == 9)) $display("FAIL ooo_all_done k=%0d got=%b exp=%b", k, all_done, (k == 9)); else pass_cnt++;
      total_cnt++; if (ch_pending !== exp_pend) $display("FAIL ooo_pending k=%0d got=%b exp=%b", k, ch_pending, exp_pend); else pass_cnt++;
      total_cnt++; if (busy !== (k < 9)) $display("FAIL ooo_busy k=%0d got=%b exp=%b", k, busy, (k < 9)); else pass_cnt++;
    end
    cyc();
    total_cnt++; if (all_done !== 1'b0) $display("FAIL ooo_single_pulse got=%b exp=0", all_done); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    open_tile(3'b111, 16'd0);
    ch_done = 3'b111;
    cyc();
    total_cnt++; if (all_done !== 1'b1 || dup_err !== 1'b0 || busy !== 1'b0) $display("FAIL simul got done=%b dup=%b busy=%b exp 1/0/0", all_done, dup_err, busy); else pass_cnt++;
    cyc();
    total_cnt++; if (all_done !== 1'b0) $display("FAIL simul_single_pulse got=%b exp=0", all_done); else pass_cnt++;
  endtask

  task automatic test_mask();
    open_tile(3'b101, 16'd0);
    // masked done plus a start in WAIT with a different mask: both ignored
    ch_done = 3'b010;
    ch_en   = 3'b111;
    start   = 1'b1;
    cyc();
    total_cnt++; if (ch_pending !== 3'b101 || busy !== 1'b1) $display("FAIL mask_ignore pend=%b busy=%b exp 101/1", ch_pending, busy); else pass_cnt++;
    ch_done = 3'b001;
    cyc();
    total_cnt++; if (ch_pending !== 3'b100 || all_done !== 1'b0) $display("FAIL mask_bit0 pend=%b done=%b exp 100/0", ch_pending, all_done); else pass_cnt++;
    ch_done = 3'b100;
    cyc();
    total_cnt++; if (all_done !== 1'b1 || busy !== 1'b0) $display("FAIL mask_done done=%b busy=%b exp 1/0", all_done, busy); else pass_cnt++;
    cyc();
    open_tile(3'b000, 16'd0);
    total_cnt++; if (all_done !== 1'b1 || busy !== 1'b0) $display("FAIL empty_mask done=%b busy=%b exp 1/0", all_done, busy); else pass_cnt++;
    cyc();
    total_cnt++; if (all_done !== 1'b0 || busy !== 1'b0) $display("FAIL empty_after done=%b busy=%b exp 0/0", all_done, busy); else pass_cnt++;
  endtask

  task automatic test_duplicate();
    open_tile(3'b111, 16'd0);
    ch_done = 3'b001;
    cyc();
    total_cnt++; if (dup_err !== 1'b0) $display("FAIL dup_first got=%b exp=0", dup_err); else pass_cnt++;
    ch_done = 3'b001;
    cyc();
    total_cnt++; if (dup_err !== 1'b1 || ch_pending !== 3'b110) $display("FAIL dup_second dup=%b pend=%b exp 1/110", dup_err, ch_pending); else pass_cnt++;
    cyc();
    total_cnt++; if (dup_err !== 1'b0) $display("FAIL dup_single_pulse got=%b exp=0", dup_err); else pass_cnt++;
    ch_done = 3'b110;
    cyc();
    total_cnt++; if (all_done !== 1'b1 || dup_err !== 1'b0) $display("FAIL dup_complete done=%b dup=%b exp 1/0", all_done, dup_err); else pass_cnt++;
    cyc();
  endtask

  task automatic test_watchdog();
    open_tile(3'b111, 16'd8);
    for (int k = 1; k <= 8; k++) begin
      ch_done = (k == 1) ? 3'b001 : 3'b000;
      cyc();
      total_cnt++; if (timeout_err !== (k == 8)) $display("FAIL wd_timeout k=%0d got=%b exp=%b", k, timeout_err, (k == 8)); else pass_cnt++;
      total_cnt++; if (busy !== (k < 8) || all_done !== 1'b0) $display("FAIL wd_state k=%0d busy=%b done=%b exp %b/0", k, busy, all_done, (k < 8)); else pass_cnt++;
    end
    cyc();
    total_cnt++; if (timeout_err !== 1'b0 || busy !== 1'b0 || ch_pending !== 3'b000) $display("FAIL wd_after to=%b busy=%b pend=%b exp 0/0/000", timeout_err, busy, ch_pending); else pass_cnt++;
    open_tile(3'b011, 16'd8);
    for (int k = 1; k <= 8; k++) begin
      ch_done = (k == 1) ? 3'b001 : (k == 8) ? 3'b010 : 3'b000;
      cyc();
      total_cnt++; if (all_done !== (k == 8) || timeout_err !== 1'b0) $display("FAIL wd_race k=%0d done=%b to=%b exp %b/0", k, all_done, timeout_err, (k == 8)); else pass_cnt++;
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    open_tile(3'b111, 16'd0);
    ch_done = 3'b001;
    cyc();
    ch_done = 3'b010;
    cyc();
    total_cnt++; if (ch_pending !== 3'b100) $display("FAIL rst_pre pend=%b exp=100", ch_pending); else pass_cnt++;
    rst = 1'b1;
    ch_done = 3'b100;
    cyc();
    rst = 1'b0;
    total_cnt++; if ({all_done, busy, dup_err, timeout_err} !== 4'b0000 || ch_pending !== 3'b000) $display("FAIL rst_mid flags=%b pend=%b exp 0000/000", {all_done, busy, dup_err, timeout_err}, ch_pending); else pass_cnt++;
    cyc();
    total_cnt++; if (all_done !== 1'b0) $display("FAIL rst_no_pulse got=%b exp=0", all_done); else pass_cnt++;
    open_tile(3'b111, 16'd0);
    total_cnt++; if (ch_pending !== 3'b111) $display("FAIL rst_fresh pend=%b exp=111", ch_pending); else pass_cnt++;
    ch_done = 3'b100;
    cyc();
    total_cnt++; if (all_done !== 1'b0 || ch_pending !== 3'b011) $display("FAIL rst_no_stale done=%b pend=%b exp 0/011", all_done, ch_pending); else pass_cnt++;
    ch_done = 3'b011;
    cyc();
    total_cnt++; if (all_done !== 1'b1) $display("FAIL b2b_first done=%b exp=1", all_done); else pass_cnt++;
    open_tile(3'b010, 16'd0);
    total_cnt++; if (busy !== 1'b1 || ch_pending !== 3'b010 || all_done !== 1'b0) $display("FAIL b2b_accept busy=%b pend=%b done=%b exp 1/010/0", busy, ch_pending, all_done); else pass_cnt++;
    ch_done = 3'b010;
    cyc();
    total_cnt++; if (all_done !== 1'b1 || busy !== 1'b0) $display("FAIL b2b_second done=%b busy=%b exp 1/0", all_done, busy); else pass_cnt++;
    cyc();
  endtask

  initial begin
    pass_cnt       = 0;
    total_cnt      = 0;
    rst            = 1'b1;
    start          = 1'b0;
    ch_en          = 3'b000;
    ch_done        = 3'b000;
    timeout_cycles = 16'd0;
    test_reset();
    test_out_of_order();
    test_simultaneous();
    test_mask();
    test_duplicate();
    test_watchdog();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/gen_multi_done.md
Name: gen_multi_done

Overview:
- Parametrised done-aggregator for the conv tile controller.
- Tracks completion of up to NUM_CH independent load/store engines (in_fm, weight, out_fm, bias, ...) per tile.
- Emits a single one-cycle all_done pulse once every enabled channel has reported done, in any order.
- Adds a per-tile channel enable mask, a pending-status view, duplicate-done detection and a programmable watchdog timeout.

Parameters:
- NUM_CH, 3, number of done channels tracked.
- TO_W, 16, width of the timeout counter and of timeout_cycles.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that opens a new tile transaction.
- ch_en  input  NUM_CH  channel enable mask; sampled only on an accepted start.
- ch_done  input  NUM_CH  per-channel one-cycle done pulses.
- timeout_cycles  input  TO_W  watchdog limit in WAIT cycles; 0 disables the watchdog; sampled on an accepted start.
- all_done  output  1  one-cycle pulse: every enabled channel has completed.
- busy  output  1  high while a transaction is open (WAIT state).
- ch_pending  output  NUM_CH  enabled channels not yet done.
- dup_err  output  1  one-cycle pulse: a channel reported done twice in one transaction.
- timeout_err  output  1  one-cycle pulse: the watchdog expired; the transaction is aborted.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State goes to IDLE; the mask, kept and counter registers clear.
  - All outputs are 0 from the following cycle.
  - rst overrides every other input, including mid-transaction; no all_done or error pulse is generated.
- All outputs are registered.
- State machine has states IDLE and WAIT.
- IDLE:
  - ch_done is ignored.
  - start=1: latch mask<=ch_en, kept<=0, cnt<=0, limit<=timeout_cycles, then go to WAIT.
  - If ch_en==0 at start: stay in IDLE and pulse all_done in the next cycle (latency 1).
- WAIT, evaluated every cycle:
  - hit = ch_done & mask. Done pulses on unmasked channels are ignored silently.
  - dup = hit & kept. If dup is nonzero, dup_err pulses the next cycle. Kept bits are unchanged by a dup.
  - nxt = kept | hit.
  - If nxt==mask: all_done=1 in the next cycle, return to IDLE, clear kept. Latency from the last done sample to all_done is 1 cycle.
  - All channels reporting done in the same cycle count as a normal completion.
  - Else if limit!=0 and cnt==limit-1: timeout_err=1 in the next cycle, return to IDLE with no all_done.
  - Else: cnt<=cnt+1 (saturates at its maximum value; never wraps) and kept<=nxt.
  - If completion and timeout occur in the same cycle, completion wins: all_done pulses, timeout_err does not.
  - start in WAIT is ignored; no relatch.
  - ch_done in the cycle that returns to IDLE is consumed by the completion; it is not carried into the next transaction.
- busy = (state==WAIT).
- ch_pending = mask & ~kept while in WAIT; 0 in IDLE.
- all_done, dup_err and timeout_err are never high for more than one consecutive cycle.
- A new start is accepted no earlier than the cycle all_done is high, because the block is already back in IDLE in that cycle. This allows back-to-back tiles with no idle gap.

Test Plan:
- Out-of-order completion:
  - Stimulus: NUM_CH=3, ch_en=3'b111, timeout 0; ch_done bit2 at t+2, bit0 at t+5, bit1 at t+9.
  - Required: all_done only at t+10, for one cycle; ch_pending goes 111 -> 011 -> 010 -> 000; busy drops at t+10.
- Simultaneous done:
  - Stimulus: ch_done=3'b111 in a single cycle.
  - Required: all_done exactly one cycle later; dup_err stays 0.
- Mask and empty mask:
  - Stimulus: ch_en=3'b101; a bit1 pulse is ignored, and all_done follows bit0+bit2.
  - Then start with ch_en=0.
  - Required: all_done 1 cycle after start; busy stays 0.
- Duplicate done:
  - Stimulus: bit0 pulsed twice before bit1/bit2 arrive.
  - Required: dup_err single pulse after the second bit0; completion still occurs normally.
- Watchdog:
  - Stimulus: timeout_cycles=8, only bit0 arrives.
  - Required: timeout_err at the 8th WAIT cycle, no all_done, state IDLE.
  - Repeat with the last done landing on the expiry cycle.
  - Required: all_done=1 and timeout_err=0.
- Reset and back-to-back:
  - Stimulus: rst asserted mid-WAIT with 2 of 3 channels kept.
  - Required: outputs 0, ch_pending=0, and no stale completion on the next transaction.
  - Then start asserted in the all_done cycle.
  - Required: accepted; busy=1 the following cycle.
